// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared types and constants for the moving-average filter
package moving_average_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ma_state_t;

    localparam int DEF_DATA_W  = 10;
    localparam int DEF_MAX_POW = 3;
    localparam int SUM_W       = DEF_DATA_W + DEF_MAX_POW;

    function automatic int sum_width(input int data_w, input int max_pow);
        return data_w + max_pow;
    endfunction

endpackage

// File: rtl/ma_window_buffer.sv
// rtl/ma_window_buffer.sv - circular sample store with one write port and a look-back read port
module ma_window_buffer #(
    parameter int DATA_W    = 10,
    parameter int DEPTH_POW = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [DEPTH_POW-1:0] wr_ptr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [DEPTH_POW:0]   rd_offset,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0]    r_mem [2**DEPTH_POW];
    logic [DEPTH_POW-1:0] w_rd_addr;

    // Offset equal to the full depth lands on wr_ptr itself: the oldest slot, read before overwrite.
    assign w_rd_addr = DEPTH_POW'({1'b0, wr_ptr} - rd_offset);
    assign rd_data   = r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/moving_average_flex.sv
// rtl/moving_average_flex.sv - power-of-two moving average with runtime window and rounding
module moving_average_flex
    import moving_average_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_POW = DEF_MAX_POW,
    parameter int SEL_W   = $clog2(MAX_POW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe_in,
    input  logic [SEL_W-1:0]  win_sel,
    input  logic              round_en,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              filled
);

    localparam int SUM_WIDTH = sum_width(DATA_W, MAX_POW);
    localparam int K_W       = $clog2(MAX_POW + 1);
    localparam int CNT_W     = MAX_POW + 1;
    localparam logic [SUM_WIDTH:0] OUT_MAX = {{(MAX_POW + 1){1'b0}}, {DATA_W{1'b1}}};

    ma_state_t              r_state, w_state_nxt;
    logic [SUM_WIDTH-1:0]   r_sum, w_sum_nxt;
    logic [CNT_W-1:0]       r_fill_cnt, w_fill_nxt;
    logic [MAX_POW-1:0]     r_wr_ptr;
    logic [K_W-1:0]         r_k_eff, w_k_eff;
    logic [DATA_W-1:0]      r_data_out;
    logic                   r_strobe_out;

    logic [CNT_W-1:0]       w_n;
    logic                   w_restart;
    logic [DATA_W-1:0]      w_old;
    logic [SUM_WIDTH-1:0]   w_data_ext;
    logic [SUM_WIDTH:0]     w_round, w_sum_rnd, w_quot;
    logic [DATA_W-1:0]      w_avg;

    ma_window_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH_POW (MAX_POW)
    ) u_buf (
        .clk       (clk),
        .wr_en     (strobe_in),
        .wr_ptr    (r_wr_ptr),
        .wr_data   (data_in),
        .rd_offset (w_n),
        .rd_data   (w_old)
    );

    always_comb begin
        w_k_eff = K_W'(MAX_POW);
        if (win_sel <= SEL_W'(MAX_POW)) begin
            w_k_eff = K_W'(win_sel);
        end
    end

    assign w_n        = CNT_W'(1) << w_k_eff;
    assign w_restart  = (w_k_eff != r_k_eff);
    assign w_data_ext = SUM_WIDTH'(data_in);

    // A window change wins over the strobe; the coincident sample seeds the new window.
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_fill_nxt  = r_fill_cnt;
        if (w_restart) begin
            w_sum_nxt  = strobe_in ? w_data_ext : '0;
            w_fill_nxt = strobe_in ? CNT_W'(1) : '0;
        end else if (strobe_in) begin
            if (r_state == ST_FILL) begin
                w_sum_nxt  = r_sum + w_data_ext;
                w_fill_nxt = r_fill_cnt + CNT_W'(1);
            end else begin
                w_sum_nxt = r_sum + w_data_ext - SUM_WIDTH'(w_old);
            end
        end
        if (w_restart || r_state == ST_FILL) begin
            w_state_nxt = (w_fill_nxt == w_n) ? ST_RUN : ST_FILL;
        end
    end

    always_comb begin
        w_round = '0;
        if (round_en && w_k_eff != '0) begin
            w_round = (SUM_WIDTH + 1)'(1) << (w_k_eff - K_W'(1));
        end
        w_sum_rnd = {1'b0, w_sum_nxt} + w_round;
        w_quot    = w_sum_rnd >> w_k_eff;
        w_avg     = (w_quot > OUT_MAX) ? '1 : w_quot[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_sum        <= '0;
            r_fill_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_k_eff      <= '0;
            r_data_out   <= '0;
            r_strobe_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sum        <= w_sum_nxt;
            r_fill_cnt   <= w_fill_nxt;
            r_k_eff      <= w_k_eff;
            r_strobe_out <= strobe_in;
            if (strobe_in) begin
                r_wr_ptr   <= r_wr_ptr + MAX_POW'(1);
                r_data_out <= w_avg;
            end
        end
    end

    assign data_out   = r_data_out;
    assign strobe_out = r_strobe_out;
    assign filled     = (r_state == ST_RUN);

endmodule

// File: tb/tb_moving_average_flex.sv
// tb/tb_moving_average_flex.sv - self-checking bench for moving_average_flex
module tb_moving_average_flex;

    localparam int DATA_W  = 10;
    localparam int MAX_POW = 3;
    localparam int SEL_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              strobe_in = 1'b0;
    logic [SEL_W-1:0]  win_sel = '0;
    logic              round_en = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              strobe_out;
    logic              filled;

    int checks = 0;
    int errors = 0;

    int m_win[$];
    int m_k;
    int m_out;

    moving_average_flex #(
        .DATA_W  (DATA_W),
        .MAX_POW (MAX_POW),
        .SEL_W   (SEL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .win_sel    (win_sel),
        .round_en   (round_en),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .filled     (filled)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input int d, input int sel, input logic rnd);
        strobe_in = s;
        data_in   = DATA_W'(d);
        win_sel   = SEL_W'(sel);
        round_en  = rnd;
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 5, 0, 1'b0);
        checks++;
        if (data_out !== 10'd5 || filled !== 1'b1 || strobe_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: got data %0d filled %b strobe %b expected 5 1 1", data_out, filled, strobe_out);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 10'd0 || strobe_out !== 1'b0 || filled !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got data %0d strobe %b filled %b expected 0 0 0", data_out, strobe_out, filled);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_window4();
        int ins[5]  = '{4, 8, 12, 16, 20};
        int exps[5] = '{1, 3, 6, 10, 14};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ins[i], 2, 1'b0);
            checks++;
            if (strobe_out !== 1'b1 || int'(data_out) != exps[i] || filled !== (i >= 3)) begin
                errors++;
                $display("FAIL window4[%0d]: got strobe %b data %0d filled %b expected 1 %0d %b",
                         i, strobe_out, data_out, filled, exps[i], (i >= 3));
            end
        end
        drive(1'b0, 0, 2, 1'b0);
        checks++;
        if (strobe_out !== 1'b0 || data_out !== 10'd14 || filled !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got strobe %b data %0d filled %b expected 0 14 1", strobe_out, data_out, filled);
        end
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1023, 3, 1'b0);
            e = (i < 8) ? (((i + 1) * 1023) >> 3) : 1023;
            checks++;
            if (strobe_out !== 1'b1 || int'(data_out) != e || filled !== (i >= 7)) begin
                errors++;
                $display("FAIL full_scale[%0d]: got strobe %b data %0d filled %b expected 1 %0d %b",
                         i, strobe_out, data_out, filled, e, (i >= 7));
            end
        end
    endtask

    task automatic test_rounding();
        int exp_r[2] = '{1, 2};
        int exp_t[2] = '{0, 1};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, i + 1, 1, 1'b1);
            checks++;
            if (int'(data_out) != exp_r[i]) begin
                errors++;
                $display("FAIL round_on[%0d]: got %0d expected %0d", i, data_out, exp_r[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, i + 1, 1, 1'b0);
            checks++;
            if (int'(data_out) != exp_t[i]) begin
                errors++;
                $display("FAIL round_off[%0d]: got %0d expected %0d", i, data_out, exp_t[i]);
            end
        end
    endtask

    task automatic test_window_change();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10 * (i + 1), 2, 1'b0);
        end
        checks++;
        if (filled !== 1'b1 || data_out !== 10'd25) begin
            errors++;
            $display("FAIL change_pre: got filled %b data %0d expected 1 25", filled, data_out);
        end
        drive(1'b1, 100, 1, 1'b0);
        checks++;
        if (data_out !== 10'd50 || filled !== 1'b0) begin
            errors++;
            $display("FAIL change_first: got data %0d filled %b expected 50 0", data_out, filled);
        end
        drive(1'b1, 100, 1, 1'b0);
        checks++;
        if (data_out !== 10'd100 || filled !== 1'b1) begin
            errors++;
            $display("FAIL change_second: got data %0d filled %b expected 100 1", data_out, filled);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 200, 3, 1'b0);
        end
        do_reset();
        drive(1'b1, 8, 3, 1'b0);
        checks++;
        if (data_out !== 10'd1 || filled !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first: got data %0d filled %b expected 1 0", data_out, filled);
        end
        drive(1'b1, 8, 3, 1'b0);
        checks++;
        if (data_out !== 10'd2 || filled !== 1'b0) begin
            errors++;
            $display("FAIL midreset_second: got data %0d filled %b expected 2 0", data_out, filled);
        end
    endtask

    task automatic test_random();
        int   sel;
        logic rnd;
        logic s;
        int   d;
        int   k;
        int   sum;
        int   r;
        logic exp_f;
        do_reset();
        m_win.delete();
        m_k   = 0;
        m_out = 0;
        sel   = 3;
        rnd   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) sel = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) rnd = ~rnd;
            s = ($urandom_range(0, 9) < 7);
            d = $urandom_range(0, 1023);
            k = (sel > MAX_POW) ? MAX_POW : sel;
            if (k != m_k) begin
                m_win.delete();
                m_k = k;
            end
            if (s) begin
                m_win.push_back(d);
                while (m_win.size() > (1 << k)) void'(m_win.pop_front());
                sum = 0;
                foreach (m_win[j]) sum += m_win[j];
                r = (rnd && k > 0) ? (1 << (k - 1)) : 0;
                m_out = (sum + r) >> k;
                if (m_out > 1023) m_out = 1023;
            end
            exp_f = (m_win.size() == (1 << k));
            drive(s, d, sel, rnd);
            checks++;
            if (strobe_out !== s || data_out !== DATA_W'(m_out) || filled !== exp_f) begin
                errors++;
                $display("FAIL random[%0d]: got strobe %b data %0d filled %b expected %b %0d %b",
                         i, strobe_out, data_out, filled, s, m_out, exp_f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window4();
        test_saturation();
        test_rounding();
        test_window_change();
        test_midstream_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
